gcd_binary_hs: RTL and testbench

//  Parametrised successor to the subtractive GCD peripheral. Computes gcd(in1,in2) of unsigned

---
 rtl/gcd_binary_hs.sv | 172 +++++++++++++++++
 tb/tb_gcd_binary_hs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_binary_hs.sv
// gcd_binary_hs: binary (Stein) GCD engine with a start/busy/done handshake.
// It supports abort, short-circuits zero operands, and reports a coprime flag
// and the number of busy cycles used.
module gcd_binary_hs #(
   parameter int GCDw = 32,
   parameter int CNTw = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [GCDw-1:0] in1,
   input  logic [GCDw-1:0] in2,
   output logic            busy,
   output logic            done,
   output logic [GCDw-1:0] gcd,
   output logic            coprime,
   output logic            zero_in,
   output logic [CNTw-1:0] cycles
);

   localparam int KW = $clog2(GCDw) + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      REDUCE = 3'd2,
      FINAL  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [GCDw-1:0] a_q, a_d;
   logic [GCDw-1:0] b_q, b_d;
   logic [KW-1:0]   k_q, k_d;
   logic [CNTw-1:0] cnt_q, cnt_d;
   logic [GCDw-1:0] gcd_q, gcd_d;
   logic            coprime_q, coprime_d;
   logic            zero_in_q, zero_in_d;
   logic [CNTw-1:0] cycles_q, cycles_d;

   logic            accept;
   logic            any_zero;
   logic [GCDw-1:0] or_in;
   logic [CNTw-1:0] cnt_inc;
   logic            a_gt_b;
   logic [GCDw-1:0] diff;
   logic [GCDw-1:0] result_shift;

   // Shared helper terms: accept condition, saturating count, single subtractor and result shifter.
   always_comb begin
      accept       = start && ((state_q == IDLE) || (state_q == DONE));
      or_in        = in1 | in2;
      any_zero     = (in1 == '0) || (in2 == '0);
      cnt_inc      = (cnt_q == {CNTw{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      a_gt_b       = a_q > b_q;
      diff         = a_gt_b ? (a_q - b_q) : (b_q - a_q);
      result_shift = a_q << k_q;
   end

   // State and datapath registers, cleared asynchronously so no partial result survives reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         k_q       <= '0;
         cnt_q     <= '0;
         gcd_q     <= '0;
         coprime_q <= 1'b0;
         zero_in_q <= 1'b0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         gcd_q     <= gcd_d;
         coprime_q <= coprime_d;
         zero_in_q <= zero_in_d;
         cycles_q  <= cycles_d;
      end
   end

   // Next-state logic; abort takes priority over every busy-state transition, including FINAL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) state_d = any_zero ? DONE : SHIFT;
         end
         SHIFT: begin
            if (abort)                  state_d = IDLE;
            else if (a_q[0] || b_q[0])  state_d = REDUCE;
         end
         REDUCE: begin
            if (abort)                                   state_d = IDLE;
            else if (a_q[0] && b_q[0] && (a_q == b_q))   state_d = FINAL;
         end
         FINAL: begin
            state_d = abort ? IDLE : DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: load on accept, Stein steps while busy, and publish the result in FINAL.
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      gcd_d     = gcd_q;
      coprime_d = coprime_q;
      zero_in_d = zero_in_q;
      cycles_d  = cycles_q;
      if (accept) begin
         a_d   = in1;
         b_d   = in2;
         k_d   = '0;
         cnt_d = '0;
         if (any_zero) begin
            gcd_d     = or_in;
            zero_in_d = (or_in == '0);
            coprime_d = (or_in == GCDw'(1));
            cycles_d  = '0;
         end else begin
            zero_in_d = 1'b0;
         end
      end else if (!abort) begin
         case (state_q)
            SHIFT: begin
               cnt_d = cnt_inc;
               if (!a_q[0] && !b_q[0]) begin
                  a_d = a_q >> 1;
                  b_d = b_q >> 1;
                  k_d = k_q + 1'b1;
               end
            end
            REDUCE: begin
               cnt_d = cnt_inc;
               if (!a_q[0])             a_d = a_q >> 1;
               else if (!b_q[0])        b_d = b_q >> 1;
               else if (a_q == b_q)     a_d = a_q;
               else if (a_gt_b)         a_d = diff >> 1;
               else                     b_d = diff >> 1;
            end
            FINAL: begin
               cnt_d     = cnt_inc;
               gcd_d     = result_shift;
               coprime_d = (result_shift == GCDw'(1));
               cycles_d  = cnt_inc;
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end
   end

   // Handshake outputs decoded from the registered state, so busy and done are never both high.
   always_comb begin
      busy    = (state_q == SHIFT) || (state_q == REDUCE) || (state_q == FINAL);
      done    = (state_q == DONE);
      gcd     = gcd_q;
      coprime = coprime_q;
      zero_in = zero_in_q;
      cycles  = cycles_q;
   end

endmodule

// File: tb/tb_gcd_binary_hs.sv
// tb_gcd_binary_hs: directed and randomized checks of gcd_binary_hs at GCDw=32.
module tb_gcd_binary_hs;

   localparam int GCDw = 32;
   localparam int CNTw = 8;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            abort;
   logic [GCDw-1:0] in1;
   logic [GCDw-1:0] in2;
   logic            busy;
   logic            done;
   logic [GCDw-1:0] gcd;
   logic            coprime;
   logic            zero_in;
   logic [CNTw-1:0] cycles;

   int errors = 0;
   int checks = 0;

   gcd_binary_hs #(.GCDw(GCDw), .CNTw(CNTw)) dut (
      .clk     (clk),
      .reset   (rst_n),
      .start   (start),
      .abort   (abort),
      .in1     (in1),
      .in2     (in2),
      .busy    (busy),
      .done    (done),
      .gcd     (gcd),
      .coprime (coprime),
      .zero_in (zero_in),
      .cycles  (cycles)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] euclid(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] p, q, t;
      p = x;
      q = y;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [31:0] x, input logic [31:0] y);
      start = s;
      in1   = x;
      in2   = y;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation and waits for done; lat counts sampled cycles after the accept edge.
   task automatic runOp(input logic [31:0] x, input logic [31:0] y, output int lat, output int bc);
      applyStimulus(1'b1, x, y);
      nextCycle();
      start = 1'b0;
      lat = 0;
      bc  = 0;
      while (!done && lat < 200) begin
         if (busy) bc++;
         nextCycle();
         lat++;
      end
      checkOutput("done_reached", done, 1);
   endtask

   initial begin
      int lat;
      int bc;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] g;

      rst_n = 1'b0;
      abort = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0);
      nextCycle();
      nextCycle();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_gcd", gcd, 0);
      checkOutput("rst_cycles", cycles, 0);
      checkOutput("rst_coprime", coprime, 0);
      checkOutput("rst_zero_in", zero_in, 0);
      rst_n = 1'b1;
      nextCycle();

      $display("[TB] basic operation 48/18");
      runOp(32'd48, 32'd18, lat, bc);
      checkOutput("t1_busy_cycles", bc, 8);
      checkOutput("t1_gcd", gcd, 6);
      checkOutput("t1_cycles", cycles, 8);
      checkOutput("t1_coprime", coprime, 0);
      checkOutput("t1_zero_in", zero_in, 0);
      checkOutput("t1_busy_low", busy, 0);

      $display("[TB] coprime and zero operands");
      runOp(32'd17, 32'd5, lat, bc);
      checkOutput("t2_gcd", gcd, 1);
      checkOutput("t2_coprime", coprime, 1);
      checkOutput("t2_cycles", cycles, 7);
      runOp(32'd0, 32'd0, lat, bc);
      checkOutput("t2z_latency", lat, 0);
      checkOutput("t2z_gcd", gcd, 0);
      checkOutput("t2z_zero_in", zero_in, 1);
      checkOutput("t2z_cycles", cycles, 0);
      checkOutput("t2z_coprime", coprime, 0);

      $display("[TB] one zero operand and worst-case operands");
      runOp(32'd0, 32'd36, lat, bc);
      checkOutput("t3_latency", lat, 0);
      checkOutput("t3_gcd", gcd, 36);
      checkOutput("t3_zero_in", zero_in, 0);
      runOp(32'hFFFF_FFFF, 32'hFFFF_FFFE, lat, bc);
      checkOutput("t3_big_gcd", gcd, 1);
      checkOutput("t3_big_coprime", coprime, 1);
      checkOutput("t3_big_cycles", cycles, 65);
      checkOutput("t3_big_busy", bc, 65);
      checkOutput("t3_big_bound", (bc <= 2 * GCDw + 2), 1);

      $display("[TB] abort during busy");
      runOp(32'd48, 32'd18, lat, bc);
      applyStimulus(1'b1, 32'd48, 32'd18);
      nextCycle();
      start = 1'b0;
      nextCycle();
      nextCycle();
      checkOutput("t4_busy_before_abort", busy, 1);
      abort = 1'b1;
      nextCycle();
      abort = 1'b0;
      checkOutput("t4_busy", busy, 0);
      checkOutput("t4_done", done, 0);
      checkOutput("t4_gcd_kept", gcd, 6);
      checkOutput("t4_cycles_kept", cycles, 8);
      checkOutput("t4_coprime_kept", coprime, 0);
      nextCycle();
      checkOutput("t4_idle_stays", busy | done, 0);
      runOp(32'd12, 32'd8, lat, bc);
      checkOutput("t4_next_gcd", gcd, 4);

      $display("[TB] start held during busy");
      applyStimulus(1'b1, 32'd48, 32'd18);
      nextCycle();
      applyStimulus(1'b1, 32'd100, 32'd75);
      lat = 0;
      while (!done && lat < 200) begin
         nextCycle();
         lat++;
      end
      checkOutput("t5_done", done, 1);
      checkOutput("t5_gcd", gcd, 6);
      checkOutput("t5_cycles", cycles, 8);
      nextCycle();
      start = 1'b0;
      checkOutput("t5_done_dropped", done, 0);
      checkOutput("t5_reaccepted", busy, 1);
      lat = 0;
      while (!done && lat < 200) begin
         nextCycle();
         lat++;
      end
      checkOutput("t5_second_done", done, 1);
      checkOutput("t5_second_gcd", gcd, 25);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 32'd48, 32'd18);
      nextCycle();
      start = 1'b0;
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("t6_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_done", done, 0);
      checkOutput("t6_gcd", gcd, 0);
      checkOutput("t6_cycles", cycles, 0);
      checkOutput("t6_coprime", coprime, 0);
      checkOutput("t6_zero_in", zero_in, 0);
      nextCycle();
      rst_n = 1'b1;
      nextCycle();
      checkOutput("t6_idle_after", busy | done, 0);

      $display("[TB] random sweep");
      for (int i = 0; i < 300; i++) begin
         x = $urandom;
         y = $urandom;
         if (i % 3 == 0) begin
            x = x & 32'hFF;
            y = y & 32'hFF;
         end
         if (i % 4 == 1) begin
            x = (x >> 8) << 5;
            y = (y >> 8) << 5;
         end
         g = euclid(x, y);
         runOp(x, y, lat, bc);
         checkOutput("rand_gcd", gcd, g);
         checkOutput("rand_coprime", coprime, (g == 32'd1));
         checkOutput("rand_zero_in", zero_in, ((x | y) == 32'd0));
         checkOutput("rand_bound", (bc <= 2 * GCDw + 2), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
